assist_lvl_ctrl: RTL and testbench

Push-button assist-level controller for the eBike rider interface. It synchronises the raw active-low button, debounces it, and classifies each press as short or long. A short press steps the motor assist level; a long press forces assist off. The registered level and its event pulses feed the torque/assist scaling logic.

---
 rtl/assist_pkg.sv | 18 +
 rtl/pb_sync.sv | 24 ++
 rtl/assist_lvl_ctrl.sv | 124 ++++++++++++
 tb/tb_assist_lvl_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/assist_pkg.sv
// Shared types and constants for the push-button assist-level controller.
`timescale 1ns/1ps
package assist_pkg;

    // Press-classification FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DEB   = 2'd1,
        PRESS = 2'd2,
        HELD  = 2'd3
    } pb_state_t;

    // Motor assist level, 0 = off, 3 = maximum.
    typedef logic [1:0] assist_t;

    localparam assist_t ASSIST_MAX = 2'd3;

endpackage

// File: rtl/pb_sync.sv
// Two-flop synchroniser for the raw push-button. Both flops reset to 1 so a
// reset looks like a released button to the downstream FSM.
`timescale 1ns/1ps
module pb_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_p0;

    // Metastability filter: d -> meta_p0 -> q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_p0 <= 1'b1;
            q       <= 1'b1;
        end else begin
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/assist_lvl_ctrl.sv
// Push-button assist-level controller: synchronises and debounces the raw
// active-low button, classifies presses as short or long, and keeps the
// registered assist level with one-cycle change / long-press pulses.
//
// Build option: define ASSIST_WRAP_EN to let a short press at level 3 wrap
// the level back to 0; otherwise the level saturates at 3.
`timescale 1ns/1ps
module assist_lvl_ctrl
    import assist_pkg::*;
#(
    parameter int DEB_CYC  = 50_000,
    parameter int LONG_CYC = 50_000_000
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    pb,
    output assist_t assist_lvl,
    output logic    lvl_chg,
    output logic    long_press,
    output logic    btn_held
);

    localparam int CNT_W = $clog2(LONG_CYC + 1);

    // Compare against "threshold - 1" so the current sample completes the run.
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(LONG_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    pb_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             pb_s;

    // Saturating press counter step; it never wraps past LONG_CYC.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_ONE;
    endfunction

    // Level reached by a short press from level l.
    function automatic assist_t lvl_step(input assist_t l);
`ifdef ASSIST_WRAP_EN
        return l + 2'd1;
`else
        return (l == ASSIST_MAX) ? l : l + 2'd1;
`endif
    endfunction

    pb_sync u_pb_sync (
        .clk (clk),
        .rst (rst),
        .d   (pb),
        .q   (pb_s)
    );

    // Press FSM, low-sample counter, level register and event pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            assist_lvl <= '0;
            lvl_chg    <= 1'b0;
            long_press <= 1'b0;
            btn_held   <= 1'b0;
        end else begin
            lvl_chg    <= 1'b0;
            long_press <= 1'b0;
            case (state)
                IDLE: begin
                    if (!pb_s) begin
                        state <= DEB;
                        cnt   <= CNT_ONE;
                    end
                end
                DEB: begin
                    if (pb_s) begin
                        // Glitch shorter than the debounce window: drop it.
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state    <= PRESS;
                        cnt      <= cnt_inc(cnt);
                        btn_held <= 1'b1;
                    end else begin
                        cnt <= cnt_inc(cnt);
                    end
                end
                PRESS: begin
                    if (pb_s) begin
                        // Short press: step the level (may be a no-op at max).
                        state      <= IDLE;
                        cnt        <= '0;
                        btn_held   <= 1'b0;
                        assist_lvl <= lvl_step(assist_lvl);
                        lvl_chg    <= (lvl_step(assist_lvl) != assist_lvl);
                    end else if (cnt == LONG_LAST) begin
                        // Long press: force assist off while still held.
                        state      <= HELD;
                        cnt        <= cnt_inc(cnt);
                        long_press <= 1'b1;
                        assist_lvl <= '0;
                        lvl_chg    <= (assist_lvl != '0);
                    end else begin
                        cnt <= cnt_inc(cnt);
                    end
                end
                HELD: begin
                    // Release after a long press changes nothing.
                    if (pb_s) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        btn_held <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    btn_held <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_assist_lvl_ctrl.sv
// Scoreboard bench for assist_lvl_ctrl with DEB_CYC=4, LONG_CYC=20.
`timescale 1ns/1ps
module tb_assist_lvl_ctrl;

    localparam int DEB  = 4;
    localparam int LONG = 20;

    logic       clk;
    logic       rst;
    logic       pb;
    logic [1:0] assist_lvl;
    logic       lvl_chg;
    logic       long_press;
    logic       btn_held;

    assist_lvl_ctrl #(
        .DEB_CYC  (DEB),
        .LONG_CYC (LONG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pb         (pb),
        .assist_lvl (assist_lvl),
        .lvl_chg    (lvl_chg),
        .long_press (long_press),
        .btn_held   (btn_held)
    );

    typedef struct {
        int cyc;
        int lvl;
        int chg;
        int lp;
    } ev_t;

    ev_t evq[$];
    int  hq[$];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int lvl    = 0;
    logic held_q = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference level rule for a short press.
    function automatic int step(input int l);
`ifdef ASSIST_WRAP_EN
        return (l + 1) % 4;
`else
        return (l < 3) ? l + 1 : 3;
`endif
    endfunction

    // Monitor: every pulse cycle and every btn_held rise consumes one expectation.
    always @(negedge clk) begin
        ev_t e;
        if (lvl_chg || long_press) begin
            if (evq.size() == 0) begin
                check("unexpected_event_pulse", 1, 0);
            end else begin
                e = evq.pop_front();
                check("event_cycle", cyc, e.cyc);
                check("event_assist_lvl", int'(assist_lvl), e.lvl);
                check("event_lvl_chg", int'(lvl_chg), e.chg);
                check("event_long_press", int'(long_press), e.lp);
            end
        end
        if (btn_held && !held_q) begin
            if (hq.size() == 0) check("unexpected_btn_held_rise", 1, 0);
            else check("btn_held_rise_cycle", cyc, hq.pop_front());
        end
        held_q = btn_held;
    end

    // Hold pb low for len clocks, release, idle for gap clocks. Expectations
    // come from the press length: <DEB ignored, <LONG short, else long.
    task automatic press(input int len, input int gap);
        int c;
        int nxt;
        c = cyc;
        if (len >= LONG) begin
            hq.push_back(c + DEB + 2);
            evq.push_back('{c + LONG + 2, 0, (lvl != 0) ? 1 : 0, 1});
            lvl = 0;
        end else if (len >= DEB) begin
            hq.push_back(c + DEB + 2);
            nxt = step(lvl);
            if (nxt != lvl) evq.push_back('{c + len + 3, nxt, 1, 0});
            lvl = nxt;
        end
        pb = 1'b0;
        repeat (len) @(negedge clk);
        pb = 1'b1;
        repeat (gap) @(negedge clk);
        check("level_after_press", int'(assist_lvl), lvl);
        check("btn_held_idle", int'(btn_held), 0);
    endtask

    initial begin
        int r;
        int k;
        rst = 1'b1;
        pb  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_assist_lvl", int'(assist_lvl), 0);
        check("reset_lvl_chg", int'(lvl_chg), 0);
        check("reset_long_press", int'(long_press), 0);
        check("reset_btn_held", int'(btn_held), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Glitch, three short presses, press at level 3.
        press(2, 6);
        press(8, 6);
        press(8, 6);
        press(8, 6);
        press(8, 6);
        // Long press from whatever level, climb to 2, long press, long from 0.
        press(40, 6);
        press(8, 6);
        press(8, 6);
        press(40, 6);
        press(40, 6);

        // Reset in PRESS with button still down; it must restart as a new press.
        pb = 1'b0;
        hq.push_back(cyc + DEB + 2);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset_assist_lvl", int'(assist_lvl), 0);
        check("midreset_lvl_chg", int'(lvl_chg), 0);
        check("midreset_long_press", int'(long_press), 0);
        check("midreset_btn_held", int'(btn_held), 0);
        lvl = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        r = cyc;
        hq.push_back(r + DEB + 2);
        evq.push_back('{r + 10 + 3, 1, 1, 0});
        lvl = 1;
        repeat (10) @(negedge clk);
        pb = 1'b1;
        repeat (6) @(negedge clk);
        check("level_after_reset_press", int'(assist_lvl), 1);

        // Randomised presses across all three length classes.
        for (int i = 0; i < 30; i++) begin
            k = $urandom_range(0, 2);
            if (k == 0)      press($urandom_range(1, 3), $urandom_range(5, 12));
            else if (k == 1) press($urandom_range(4, 19), $urandom_range(5, 12));
            else             press($urandom_range(20, 40), $urandom_range(5, 12));
        end

        repeat (10) @(negedge clk);
        check("pending_events", evq.size(), 0);
        check("pending_btn_held_rises", hq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
